// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's access port into the RAM arbiter.
//   req    requester -> arbiter  access request, held until granted
//   we     requester -> arbiter  1=write, 0=read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   lock   requester -> arbiter  ask to keep ownership for the next access
//   gnt    arbiter -> requester  access issued this cycle (combinational)
//   rvalid arbiter -> requester  rdata valid, one-cycle pulse
//   rdata  arbiter -> requester  read data
interface ram_port_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between the JTAG
// debug requester and the system bus requester. At most one access per
// cycle; read data is returned to the side that issued the read.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   dbg        debug requester port (slave side of ram_port_arbiter_if)
//   sys        system requester port (slave side of ram_port_arbiter_if)
//   ram_en     RAM access strobe
//   ram_we     RAM write enable
//   ram_addr   RAM word address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid the cycle after a read strobe
module ram_port_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   dbg,
    ram_port_arbiter_if.slave   sys,
    output logic                ram_en,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DBG  = 2'd1,
        OWN_SYS  = 2'd2
    } owner_t;

    typedef enum logic {
        SIDE_DBG = 1'b0,
        SIDE_SYS = 1'b1
    } side_t;

    owner_t         r_owner;
    owner_t         w_owner_nxt;
    side_t          r_rr_ptr;
    side_t          w_rr_nxt;
    logic [CW-1:0]  r_lock_cnt;
    logic [CW-1:0]  w_lock_cnt_nxt;
    logic [CW-1:0]  w_lock_cnt_inc;
    logic           r_rvalid_dbg;
    logic           r_rvalid_sys;
    logic           w_gnt_dbg;
    logic           w_gnt_sys;
    logic           w_lock_dbg;
    logic           w_lock_sys;

    // Ownership / round-robin / lock-count state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_rr_ptr   <= SIDE_DBG;
            r_lock_cnt <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Grant decision and next-state
    always_comb begin
        w_gnt_dbg      = 1'b0;
        w_gnt_sys      = 1'b0;
        w_owner_nxt    = OWN_NONE;
        w_rr_nxt       = r_rr_ptr;
        w_lock_cnt_nxt = '0;
        w_lock_cnt_inc = (r_lock_cnt >= CW'(MAX_LOCK)) ? CW'(MAX_LOCK)
                                                       : r_lock_cnt + CW'(1);

        // A locked owner keeps the port unless the other side has already
        // waited through MAX_LOCK consecutive locked grants.
        w_lock_dbg = (r_owner == OWN_DBG) && dbg.req && dbg.lock &&
                     (!sys.req || (r_lock_cnt < CW'(MAX_LOCK)));
        w_lock_sys = (r_owner == OWN_SYS) && sys.req && sys.lock &&
                     (!dbg.req || (r_lock_cnt < CW'(MAX_LOCK)));

        if (!rst) begin
            if (w_lock_dbg) begin
                w_gnt_dbg = 1'b1;
            end else if (w_lock_sys) begin
                w_gnt_sys = 1'b1;
            end else if (dbg.req && sys.req) begin
                w_gnt_dbg = (r_rr_ptr == SIDE_DBG);
                w_gnt_sys = (r_rr_ptr == SIDE_SYS);
            end else begin
                w_gnt_dbg = dbg.req;
                w_gnt_sys = sys.req;
            end
        end

        // A grant without lock, or an idle cycle, drops ownership.
        // A fresh ownership run starts counting at 1.
        if (w_gnt_dbg) begin
            w_rr_nxt = SIDE_SYS;
            if (dbg.lock) begin
                w_owner_nxt    = OWN_DBG;
                w_lock_cnt_nxt = (r_owner == OWN_DBG) ? w_lock_cnt_inc : CW'(1);
            end
        end else if (w_gnt_sys) begin
            w_rr_nxt = SIDE_DBG;
            if (sys.lock) begin
                w_owner_nxt    = OWN_SYS;
                w_lock_cnt_nxt = (r_owner == OWN_SYS) ? w_lock_cnt_inc : CW'(1);
            end
        end
    end

    // In-flight read tags: one cycle after a granted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid_dbg <= 1'b0;
            r_rvalid_sys <= 1'b0;
        end else begin
            r_rvalid_dbg <= w_gnt_dbg && !dbg.we;
            r_rvalid_sys <= w_gnt_sys && !sys.we;
        end
    end

    assign dbg.gnt = w_gnt_dbg;
    assign sys.gnt = w_gnt_sys;

    // Masking with rst drops a read that was in flight when reset arrived
    assign dbg.rvalid = r_rvalid_dbg & ~rst;
    assign sys.rvalid = r_rvalid_sys & ~rst;
    assign dbg.rdata  = ram_rdata;
    assign sys.rdata  = ram_rdata;

    // RAM drive: granted side wins, idle defaults to sys fields with we=0
    assign ram_en    = w_gnt_dbg | w_gnt_sys;
    assign ram_we    = w_gnt_dbg ? dbg.we : (w_gnt_sys ? sys.we : 1'b0);
    assign ram_addr  = w_gnt_dbg ? dbg.addr  : sys.addr;
    assign ram_wdata = w_gnt_dbg ? dbg.wdata : sys.wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural
// RAM, a reference memory and per-side read-data scoreboards.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] ram_mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] q_dbg [$];
    logic [31:0] q_sys [$];
    logic        pend_d;
    logic        pend_s;
    int          n_cmp;
    int          n_err;

    ram_port_arbiter_if #(.AW(5), .DW(32)) dbg_if ();
    ram_port_arbiter_if #(.AW(5), .DW(32)) sys_if ();

    ram_port_arbiter #(.DW(32), .AW(5), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg       (dbg_if),
        .sys       (sys_if),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag, input string what);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational and returned-read outputs,
    // update the scoreboard from the expected grants, advance the clock.
    task automatic step(input logic rst_v,
                        input logic dr, input logic dw, input logic [4:0] da,
                        input logic [31:0] dd, input logic dl,
                        input logic sr, input logic sw, input logic [4:0] sa,
                        input logic [31:0] sd, input logic sl,
                        input logic eg_d, input logic eg_s, input string tag);
        logic [31:0] exp_data;
        rst          = rst_v;
        dbg_if.req   = dr; dbg_if.we = dw; dbg_if.addr = da;
        dbg_if.wdata = dd; dbg_if.lock = dl;
        sys_if.req   = sr; sys_if.we = sw; sys_if.addr = sa;
        sys_if.wdata = sd; sys_if.lock = sl;
        #1;
        chk(32'(dbg_if.gnt), 32'(eg_d), tag, "dbg_gnt");
        chk(32'(sys_if.gnt), 32'(eg_s), tag, "sys_gnt");
        chk(32'(ram_en), 32'(eg_d | eg_s), tag, "ram_en");
        if (eg_d) begin
            chk(32'(ram_we), 32'(dw), tag, "ram_we");
            chk(32'(ram_addr), 32'(da), tag, "ram_addr");
            if (dw) chk(ram_wdata, dd, tag, "ram_wdata");
        end else if (eg_s) begin
            chk(32'(ram_we), 32'(sw), tag, "ram_we");
            chk(32'(ram_addr), 32'(sa), tag, "ram_addr");
            if (sw) chk(ram_wdata, sd, tag, "ram_wdata");
        end else begin
            chk(32'(ram_we), 32'(0), tag, "ram_we_idle");
        end

        chk(32'(dbg_if.rvalid), 32'(pend_d && !rst_v), tag, "dbg_rvalid");
        chk(32'(sys_if.rvalid), 32'(pend_s && !rst_v), tag, "sys_rvalid");
        if (pend_d && q_dbg.size() > 0) begin
            exp_data = q_dbg.pop_front();
            if (!rst_v) chk(dbg_if.rdata, exp_data, tag, "dbg_rdata");
        end
        if (pend_s && q_sys.size() > 0) begin
            exp_data = q_sys.pop_front();
            if (!rst_v) chk(sys_if.rdata, exp_data, tag, "sys_rdata");
        end

        pend_d = 1'b0;
        pend_s = 1'b0;
        if (eg_d) begin
            if (dw) ref_mem[da] = dd;
            else begin q_dbg.push_back(ref_mem[da]); pend_d = 1'b1; end
        end
        if (eg_s) begin
            if (sw) ref_mem[sa] = sd;
            else begin q_sys.push_back(ref_mem[sa]); pend_s = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst_v, input string tag);
        step(rst_v, 0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 0, tag);
    endtask

    logic [5:0] a32;

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_err = 0;
        pend_d = 1'b0;
        pend_s = 1'b0;
        ram_rdata = '0;
        dbg_if.req = 0; dbg_if.we = 0; dbg_if.addr = '0; dbg_if.wdata = '0; dbg_if.lock = 0;
        sys_if.req = 0; sys_if.we = 0; sys_if.addr = '0; sys_if.wdata = '0; sys_if.lock = 0;
        @(posedge clk);
        #1;

        // Reset sequence
        idle(1, "rst_a");
        idle(1, "rst_b");
        idle(0, "post_rst");

        // Debug only: write then read back
        step(0, 1, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "dbg_wr");
        step(0, 1, 0, 5'd3, 32'd0,        0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "dbg_rd");
        idle(0, "dbg_ret");

        // Preload words for the contention phase
        step(0, 0, 0, 5'd0, 32'd0, 0, 1, 1, 5'd8,  32'h1111_0008, 0, 0, 1, "pre8");
        step(0, 0, 0, 5'd0, 32'd0, 0, 1, 1, 5'd9,  32'h2222_0009, 0, 0, 1, "pre9");
        step(0, 1, 1, 5'd10, 32'h3333_000A, 0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "pre10");
        step(0, 1, 1, 5'd11, 32'h4444_000B, 0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "pre11");

        // Contention from reset: grants alternate starting with DBG
        idle(1, "c_rst");
        step(0, 1, 0, 5'd8,  32'd0, 0, 1, 0, 5'd9,  32'd0, 0, 1, 0, "c1");
        step(0, 1, 0, 5'd10, 32'd0, 0, 1, 0, 5'd9,  32'd0, 0, 0, 1, "c2");
        step(0, 1, 0, 5'd10, 32'd0, 0, 1, 0, 5'd11, 32'd0, 0, 1, 0, "c3");
        step(0, 1, 0, 5'd8,  32'd0, 0, 1, 0, 5'd11, 32'd0, 0, 0, 1, "c4");
        idle(0, "c_ret");

        // Lock: DBG x4, SYS x1, DBG x4, then released lock lets SYS in
        idle(1, "l_rst");
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 5'd8, 32'd0, 1, 1, 0, 5'd9, 32'd0, 0,
                 (i != 4), (i == 4), $sformatf("lock%0d", i));
        end
        step(0, 1, 0, 5'd8, 32'd0, 0, 1, 0, 5'd9, 32'd0, 0, 0, 1, "unlock");
        idle(0, "l_ret");

        // Top address write/read-after-write and address aliasing
        step(0, 0, 0, 5'd0,  32'd0, 0, 1, 1, 5'd31, 32'h0000_1234, 0, 0, 1, "w31");
        step(0, 1, 0, 5'd31, 32'd0, 0, 0, 0, 5'd0,  32'd0,         0, 1, 0, "r31");
        a32 = 6'd32;
        step(0, 1, 1, a32[4:0], 32'hCAFE_0000, 0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "w32");
        step(0, 0, 0, 5'd0, 32'd0, 0, 1, 0, 5'd0, 32'd0, 0, 0, 1, "r0");
        idle(0, "alias_ret");

        // Reset during an in-flight read, then the first tie goes to DBG
        step(0, 1, 0, 5'd3, 32'd0, 0, 0, 0, 5'd0, 32'd0, 0, 1, 0, "m_rd");
        step(1, 1, 0, 5'd3, 32'd0, 0, 1, 0, 5'd9, 32'd0, 0, 0, 0, "m_rst");
        step(0, 1, 0, 5'd3, 32'd0, 0, 1, 0, 5'd9, 32'd0, 0, 1, 0, "m_tie");
        step(0, 0, 0, 5'd0, 32'd0, 0, 1, 0, 5'd9, 32'd0, 0, 0, 1, "m_sys");
        idle(0, "m_ret");
        idle(0, "end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
